hamming_read_decoder: RTL and testbench

HAMMING_READ_DECODER -- requirements
Module: hamming_read_decoder

---
 rtl/hamming_read_decoder.sv | 154 +++++++++++++++
 tb/tb_hamming_read_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_read_decoder.sv
// rtl/hamming_read_decoder.sv - SECDED (13,8) read-path decoder with two-stage pipeline, event counters and DED address capture
module hamming_read_decoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 16,
  localparam int AW           = $clog2(ADDRESS_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [12:0]           i_code,
  input  logic [AW-1:0]         i_addr,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sec,
  output logic                  o_ded,
  output logic [3:0]            o_syndrome,
  output logic [7:0]            o_sec_count,
  output logic [7:0]            o_ded_count,
  output logic [AW-1:0]         o_err_addr,
  output logic                  o_err_addr_valid,
  input  logic                  i_clr
);

  function automatic logic [7:0] extract(input logic [12:0] c);
    return {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  logic                  s1_valid_q;
  logic [3:0]            s1_syn_q;
  logic                  s1_par_q;
  logic [7:0]            s1_data_q;
  logic [AW-1:0]         s1_addr_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_sec_q;
  logic                  out_ded_q;
  logic [3:0]            out_syn_q;
  logic [AW-1:0]         out_addr_q;
  logic [7:0]            sec_cnt_q;
  logic [7:0]            ded_cnt_q;
  logic [AW-1:0]         err_addr_q;
  logic                  err_valid_q;

  logic                  adv2;
  logic                  adv1;
  logic                  xfer;
  logic [3:0]            syn_d;
  logic                  par_d;
  logic [7:0]            raw_d;
  logic [12:0]           fix_code;
  logic [7:0]            fix_data;
  logic                  sec_d;
  logic                  ded_d;
  logic [7:0]            data_d;

  assign adv2    = !out_valid_q || i_ready;
  assign adv1    = !s1_valid_q || adv2;
  assign o_ready = adv1;
  assign xfer    = out_valid_q && i_ready;

  always_comb begin
    syn_d = '0;
    for (int k = 1; k < 13; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k[j]) syn_d[j] = syn_d[j] ^ i_code[k];
      end
    end
    par_d = ^i_code;
    raw_d = extract(i_code);
  end

  // Rebuild the data positions of the codeword so the syndrome can address the flipped bit directly.
  always_comb begin
    fix_code     = '0;
    fix_code[3]  = s1_data_q[0];
    fix_code[5]  = s1_data_q[1];
    fix_code[6]  = s1_data_q[2];
    fix_code[7]  = s1_data_q[3];
    fix_code[9]  = s1_data_q[4];
    fix_code[10] = s1_data_q[5];
    fix_code[11] = s1_data_q[6];
    fix_code[12] = s1_data_q[7];
    if (s1_par_q && s1_syn_q != 4'd0 && s1_syn_q <= 4'd12) begin
      fix_code[s1_syn_q] = ~fix_code[s1_syn_q];
    end
    fix_data = extract(fix_code);
    sec_d    = s1_par_q && (s1_syn_q <= 4'd12);
    ded_d    = s1_par_q ? (s1_syn_q > 4'd12) : (s1_syn_q != 4'd0);
    data_d   = ded_d ? s1_data_q : fix_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
      out_addr_q  <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= i_valid;
        s1_syn_q   <= syn_d;
        s1_par_q   <= par_d;
        s1_data_q  <= raw_d;
        s1_addr_q  <= i_addr;
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        out_data_q  <= data_d;
        out_sec_q   <= sec_d;
        out_ded_q   <= ded_d;
        out_syn_q   <= s1_syn_q;
        out_addr_q  <= s1_addr_q;
      end
      // Clear dominates any increment or capture landing on the same edge.
      if (i_clr) begin
        sec_cnt_q   <= '0;
        ded_cnt_q   <= '0;
        err_valid_q <= 1'b0;
      end else begin
        if (xfer && out_sec_q && sec_cnt_q != 8'hFF) sec_cnt_q <= sec_cnt_q + 8'd1;
        if (xfer && out_ded_q && ded_cnt_q != 8'hFF) ded_cnt_q <= ded_cnt_q + 8'd1;
        if (xfer && out_ded_q && !err_valid_q) begin
          err_addr_q  <= out_addr_q;
          err_valid_q <= 1'b1;
        end
      end
    end
  end

  assign o_valid          = out_valid_q;
  assign o_data           = out_data_q;
  assign o_sec            = out_sec_q;
  assign o_ded            = out_ded_q;
  assign o_syndrome       = out_syn_q;
  assign o_sec_count      = sec_cnt_q;
  assign o_ded_count      = ded_cnt_q;
  assign o_err_addr       = err_addr_q;
  assign o_err_addr_valid = err_valid_q;

endmodule

// File: tb/tb_hamming_read_decoder.sv
// tb/tb_hamming_read_decoder.sv - randomized and directed self-checking bench for hamming_read_decoder
module tb_hamming_read_decoder;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_ready, i_clr;
  logic [12:0] i_code;
  logic [AW-1:0] i_addr;
  logic        o_ready, o_valid, o_sec, o_ded, o_err_addr_valid;
  logic [7:0]  o_data, o_sec_count, o_ded_count;
  logic [3:0]  o_syndrome;
  logic [AW-1:0] o_err_addr;

  always #5 clk = ~clk;

  hamming_read_decoder #(.DATA_WIDTH(8), .ADDRESS_DEPTH(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_code(i_code), .i_addr(i_addr),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sec(o_sec), .o_ded(o_ded), .o_syndrome(o_syndrome),
    .o_sec_count(o_sec_count), .o_ded_count(o_ded_count),
    .o_err_addr(o_err_addr), .o_err_addr_valid(o_err_addr_valid), .i_clr(i_clr)
  );

  typedef struct {
    logic [12:0] code;
    logic [AW-1:0] addr;
    int          acc;
    bit          seen;
    bit          lit;
    logic [7:0]  ld;
    logic        ls;
    logic        lded;
    logic [3:0]  lsyn;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_sec = 0;
  int m_ded = 0;
  logic [AW-1:0] m_addr = '0;
  bit m_aval = 0;

  bit nlit = 0;
  logic [7:0] nld;
  logic nls, nlded;
  logic [3:0] nlsyn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: syndrome as XOR of the indices of set bits.
  function automatic void decode(input logic [12:0] c, output logic [7:0] d,
                                 output logic sec, output logic ded, output logic [3:0] syn);
    int s = 0;
    int p = 0;
    int pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [12:0] cc = c;
    for (int k = 1; k <= 12; k++) if (c[k]) s = s ^ k;
    for (int k = 0; k <= 12; k++) p = p ^ int'(c[k]);
    sec = (p == 1) && (s <= 12);
    ded = ((p == 1) && (s > 12)) || ((p == 0) && (s != 0));
    if (sec && s != 0) cc[s] = ~cc[s];
    for (int i = 0; i < 8; i++) d[i] = cc[pos[i]];
    syn = s[3:0];
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    int pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [12:0] c = '0;
    int s = 0;
    for (int i = 0; i < 8; i++) c[pos[i]] = d[i];
    for (int k = 1; k <= 12; k++) if (c[k]) s = s ^ k;
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[12:1];
    return c;
  endfunction

  always @(negedge clk) begin
    logic [7:0] ed;
    logic es, eded;
    logic [3:0] esyn;
    bit xfer;
    bit xs, xd;
    logic [AW-1:0] xa;
    cyc++;
    chk("sec_count", o_sec_count, m_sec);
    chk("ded_count", o_ded_count, m_ded);
    chk("err_addr_valid", o_err_addr_valid, m_aval);
    chk("err_addr", o_err_addr, m_addr);
    if (i_rst) begin
      q.delete();
      m_sec = 0; m_ded = 0; m_addr = '0; m_aval = 0;
    end else begin
      xfer = 0; xs = 0; xd = 0; xa = '0;
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          decode(q[0].code, ed, es, eded, esyn);
          chk("data", o_data, ed);
          chk("sec", o_sec, es);
          chk("ded", o_ded, eded);
          chk("syndrome", o_syndrome, esyn);
          if (!q[0].seen) begin
            q[0].seen = 1;
            chk("latency_min", (cyc - q[0].acc >= 2), 1);
          end
          if (q[0].lit) begin
            chk("lit_data", o_data, q[0].ld);
            chk("lit_sec", o_sec, q[0].ls);
            chk("lit_ded", o_ded, q[0].lded);
            chk("lit_syndrome", o_syndrome, q[0].lsyn);
          end
          if (i_ready) begin
            xfer = 1; xs = es; xd = eded; xa = q[0].addr;
            void'(q.pop_front());
          end
        end
      end
      if (i_clr) begin
        m_sec = 0; m_ded = 0; m_aval = 0;
      end else if (xfer) begin
        if (xs && m_sec < 255) m_sec++;
        if (xd && m_ded < 255) m_ded++;
        if (xd && !m_aval) begin m_aval = 1; m_addr = xa; end
      end
      if (i_valid && o_ready) begin
        q.push_back('{code: i_code, addr: i_addr, acc: cyc, seen: 0,
                      lit: nlit, ld: nld, ls: nls, lded: nlded, lsyn: nlsyn});
        chk("in_flight_le2", (q.size() <= 2), 1);
      end
    end
  end

  task automatic send(input logic [12:0] c, input logic [AW-1:0] a);
    i_valid = 1; i_code = c; i_addr = a;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (o_ready) break;
      if (t > 50) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    i_valid = 0; nlit = 0;
  endtask

  task automatic setlit(input logic [7:0] d, input logic s, input logic dd, input logic [3:0] sy);
    nlit = 1; nld = d; nls = s; nlded = dd; nlsyn = sy;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] c;
    i_rst = 1; i_valid = 0; i_ready = 1; i_clr = 0; i_code = '0; i_addr = '0;
    idle(2);
    i_rst = 0;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_flags", {o_sec, o_ded}, 0);
    chk("rst_syn", o_syndrome, 0);
    chk("rst_counts", {o_sec_count, o_ded_count}, 0);
    chk("rst_erraddr", {o_err_addr_valid, o_err_addr}, 0);
    @(posedge clk); #1;

    // model pin: encoder of 0xA5 must give the documented clean codeword
    c = encode(8'hA5);
    chk("model_encode_a5", c, 13'h144E);

    setlit(8'hA5, 0, 0, 4'd0);
    send(13'h144E, 4'd1);
    @(negedge clk);
    chk("lat_one_edge", o_valid, 0);
    @(negedge clk);
    chk("lat_two_edges", o_valid, 1);
    @(posedge clk); #1;

    setlit(8'hA5, 1, 0, 4'd6);
    send(13'h140E, 4'd2);
    idle(3);
    @(negedge clk);
    chk("lit_sec_count_1", o_sec_count, 1);
    @(posedge clk); #1;

    setlit(8'hA5, 1, 0, 4'd0);
    send(13'h144F, 4'd3);
    setlit(8'hA6, 0, 1, 4'd6);
    send(13'h1466, 4'd5);
    send(13'h1466, 4'd9);
    idle(3);
    @(negedge clk);
    chk("lit_err_addr", o_err_addr, 5);
    chk("lit_err_valid", o_err_addr_valid, 1);
    @(posedge clk); #1;

    // backpressure: two accepted with consumer stalled, third must see o_ready low
    i_ready = 0;
    send(encode(8'h11), 4'd0);
    send(encode(8'h22) ^ 13'h0100, 4'd1);
    i_valid = 1; i_code = encode(8'h33); i_addr = 4'd2;
    @(negedge clk);
    chk("bp_ready_low", o_ready, 0);
    idle(2);
    i_ready = 1;
    send(encode(8'h33), 4'd2);
    send(encode(8'h44) ^ 13'h0011, 4'd3);
    idle(3);

    for (int n = 0; n < 300; n++) send(13'h1466, 4'(n));
    idle(3);
    @(negedge clk);
    chk("lit_ded_sat", o_ded_count, 255);
    @(posedge clk); #1;

    i_clr = 1; idle(1); i_clr = 0;
    i_ready = 0;
    send(13'h1466, 4'd7);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (o_valid) break;
      if (t > 20) begin chk("valid_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    i_ready = 1; i_clr = 1;
    idle(1);
    i_clr = 0;
    @(negedge clk);
    chk("lit_clr_count", o_ded_count, 0);
    chk("lit_clr_aval", o_err_addr_valid, 0);
    @(posedge clk); #1;

    for (int n = 0; n < 3000; n++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      c = encode(8'($urandom));
      if (mode == 1) c = c ^ (13'd1 << $urandom_range(0, 12));
      if (mode == 2) c = c ^ (13'd1 << $urandom_range(0, 12)) ^ (13'd1 << $urandom_range(0, 12));
      if (mode == 3) c = 13'($urandom);
      i_code  = c;
      i_addr  = 4'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = (n % 400 < 200) ? 1'b1 : ($urandom_range(0, 1) == 1);
      i_clr   = ($urandom_range(0, 63) == 0);
      i_rst   = (n == 1500);
      idle(1);
    end
    i_valid = 0; i_ready = 1; i_clr = 0; i_rst = 0;
    idle(6);
    chk("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
